// File: rtl/instr_sequencer_if.sv
// Bus bundle for instr_sequencer.
//   master : drives decode/ALU/memory-status inputs (datapath side, or a testbench).
//   slave  : the sequencer; drives PC and the control strobes.
// Inputs : I_BUSYWAIT, D_BUSYWAIT, IS_JUMP, IS_BRANCH, MEM_RD_REQ, MEM_WR_REQ,
//          REG_WR_REQ, ZERO, OFFSET[7:0]
// Outputs: PC[31:0], I_READ, IR_LOAD, D_READ, D_WRITE, REG_WRITE, WB_SEL_MEM, FAULT
interface instr_sequencer_if;
  logic        I_BUSYWAIT;
  logic        D_BUSYWAIT;
  logic        IS_JUMP;
  logic        IS_BRANCH;
  logic        MEM_RD_REQ;
  logic        MEM_WR_REQ;
  logic        REG_WR_REQ;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC;
  logic        I_READ;
  logic        IR_LOAD;
  logic        D_READ;
  logic        D_WRITE;
  logic        REG_WRITE;
  logic        WB_SEL_MEM;
  logic        FAULT;

  modport master (
    output I_BUSYWAIT, D_BUSYWAIT, IS_JUMP, IS_BRANCH, MEM_RD_REQ, MEM_WR_REQ,
           REG_WR_REQ, ZERO, OFFSET,
    input  PC, I_READ, IR_LOAD, D_READ, D_WRITE, REG_WRITE, WB_SEL_MEM, FAULT
  );

  modport slave (
    input  I_BUSYWAIT, D_BUSYWAIT, IS_JUMP, IS_BRANCH, MEM_RD_REQ, MEM_WR_REQ,
           REG_WR_REQ, ZERO, OFFSET,
    output PC, I_READ, IR_LOAD, D_READ, D_WRITE, REG_WRITE, WB_SEL_MEM, FAULT
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/EXEC/MEM/WB control sequencer for the 8-bit CPU.
// Owns the PC, stalls on instruction/data BUSYWAIT, and gates reg-file writes so each
// instruction produces at most one REG_WRITE pulse.
// Ports:
//   CLK      clock, all state changes on posedge
//   RESET_N  asynchronous active-low reset
//   bus      instr_sequencer_if.slave (decode inputs, memory stalls, PC and strobes)
// Parameters: PC_RESET (reset PC), TIMEOUT_CYCLES (stall limit, timeout build only).
// Build option: define SEQ_TIMEOUT_EN to enable the stall watchdog, FAULT flag and HALT.
module instr_sequencer #(
  parameter logic [31:0] PC_RESET       = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              CLK,
  input logic              RESET_N,
  instr_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ir_load_q, ir_load_d;
  logic        d_read_q, d_read_d;
  logic        d_write_q, d_write_d;
  logic        take;
  logic [31:0] pc_next;

  // Branch/jump target: word offset, sign-extended, relative to PC+4.
  assign take    = bus.IS_JUMP | (bus.IS_BRANCH & bus.ZERO);
  assign pc_next = pc_q + 32'd4 + (take ? {{22{bus.OFFSET[7]}}, bus.OFFSET, 2'b00} : 32'd0);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
  logic       stall;
  assign stall = ((state_q == S_FETCH) & bus.I_BUSYWAIT) | ((state_q == S_MEM) & bus.D_BUSYWAIT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_load_d = 1'b0;
    d_read_d  = d_read_q;
    d_write_d = d_write_q;
    case (state_q)
      S_FETCH: if (!bus.I_BUSYWAIT) begin
        state_d   = S_EXEC;
        ir_load_d = 1'b1;
      end
      S_EXEC: if (bus.MEM_RD_REQ | bus.MEM_WR_REQ) begin
        state_d   = S_MEM;
        // Data strobes are registered here so MEM sees only flop-driven strobes;
        // read wins over write when both are decoded.
        d_read_d  = bus.MEM_RD_REQ;
        d_write_d = bus.MEM_WR_REQ & ~bus.MEM_RD_REQ;
      end else begin
        pc_d    = pc_next;
        state_d = S_FETCH;
      end
      S_MEM: if (!bus.D_BUSYWAIT) begin
        d_read_d  = 1'b0;
        d_write_d = 1'b0;
        if (d_read_q) state_d = S_WB;
        else begin
          pc_d    = pc_next;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        pc_d    = pc_next;
        state_d = S_FETCH;
      end
      default: ;  // S_HALT: terminal until reset
    endcase

`ifdef SEQ_TIMEOUT_EN
    fault_d = fault_q;
    wait_d  = wait_q;
    if (state_d != state_q) wait_d = 8'd0;
    else if (stall) begin
      if (wait_q >= WAIT_LAST) begin
        state_d   = S_HALT;
        fault_d   = 1'b1;
        d_read_d  = 1'b0;
        d_write_d = 1'b0;
        pc_d      = pc_q;
        wait_d    = 8'd0;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_FETCH;
      pc_q      <= PC_RESET;
      ir_load_q <= 1'b0;
      d_read_q  <= 1'b0;
      d_write_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wait_q    <= 8'd0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_load_q <= ir_load_d;
      d_read_q  <= d_read_d;
      d_write_q <= d_write_d;
`ifdef SEQ_TIMEOUT_EN
      wait_q    <= wait_d;
      fault_q   <= fault_d;
`endif
    end
  end

  // I_READ is qualified by RESET_N so no fetch is requested while reset is held;
  // the first fetch completes on the first posedge after release.
  assign bus.PC         = pc_q;
  assign bus.I_READ     = RESET_N & (state_q == S_FETCH);
  assign bus.IR_LOAD    = ir_load_q;
  assign bus.D_READ     = d_read_q;
  assign bus.D_WRITE    = d_write_q;
  // Decode inputs come from the latched IR, so they are stable for the whole instruction.
  assign bus.REG_WRITE  = ((state_q == S_EXEC) & bus.REG_WR_REQ & ~(bus.MEM_RD_REQ | bus.MEM_WR_REQ))
                        | (state_q == S_WB);
  assign bus.WB_SEL_MEM = (state_q == S_WB);
`ifdef SEQ_TIMEOUT_EN
  assign bus.FAULT      = fault_q;
`else
  assign bus.FAULT      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed instruction table, reset-abort
// sequence, randomized instructions against a per-instruction reference model, and the
// stall-watchdog behaviour (SEQ_TIMEOUT_EN build) or unbounded-stall behaviour (default).
module tb_instr_sequencer;

  logic clk;
  logic rst_n;
  int   nchk = 0;
  int   nerr = 0;

  instr_sequencer_if bus_if ();

`ifdef SEQ_TIMEOUT_EN
  instr_sequencer #(.PC_RESET(32'h0), .TIMEOUT_CYCLES(4)) dut (
`else
  instr_sequencer #(.PC_RESET(32'h0), .TIMEOUT_CYCLES(255)) dut (
`endif
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jmp, br, rd, wr, rw, z;
    logic [7:0]  off;
    int          ib, db;
    logic [31:0] exp_pc;
    int          exp_lat, exp_rw;
  } vec_t;

  vec_t        tbl[13];
  logic [31:0] pc_model;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: next PC and cycle counts from the instruction's class.
  function automatic logic [31:0] model_pc(input logic [31:0] pc, input logic jmp,
                                           input logic br, input logic z, input logic [7:0] off);
    int so;
    so = int'($signed(off));
    if (jmp || (br && z)) return pc + 32'd4 + 32'(so * 4);
    return pc + 32'd4;
  endfunction

  function automatic int model_lat(input vec_t v);
    if (v.rd || v.wr) return 2 + v.ib + 1 + v.db + (v.rd ? 1 : 0);
    return 2 + v.ib;
  endfunction

  // Runs one instruction starting just after a negedge with the DUT in FETCH.
  // Acts as instruction/data memory, stalling for v.ib / v.db cycles.
  task automatic run_instr(input string nm, input vec_t v);
    int n = 0, nir = 0, nrw = 0, nrd = 0, nwr = 0, nwb = 0, bad = 0, pcmv = 0, nflt = 0;
    int ib_left, db_left;
    logic seen_ir = 1'b0, done = 1'b0;
    logic [31:0] start_pc;
    ib_left = v.ib;
    db_left = v.db;
    start_pc = bus_if.PC;
    bus_if.IS_JUMP    = v.jmp;
    bus_if.IS_BRANCH  = v.br;
    bus_if.MEM_RD_REQ = v.rd;
    bus_if.MEM_WR_REQ = v.wr;
    bus_if.REG_WR_REQ = v.rw;
    bus_if.ZERO       = v.z;
    bus_if.OFFSET     = v.off;
    while (!done && n < 1000) begin
      if (seen_ir && bus_if.I_READ) done = 1'b1;
      else begin
        n++;
        if (bus_if.IR_LOAD) begin nir++; seen_ir = 1'b1; end
        if (bus_if.REG_WRITE) nrw++;
        if (bus_if.REG_WRITE && (bus_if.I_READ || bus_if.D_READ || bus_if.D_WRITE)) bad++;
        if (bus_if.WB_SEL_MEM) begin nwb++; if (!bus_if.REG_WRITE) bad++; end
        if (bus_if.D_READ) nrd++;
        if (bus_if.D_WRITE) nwr++;
        if (bus_if.FAULT) nflt++;
        if (bus_if.PC !== start_pc) pcmv++;
        if (bus_if.I_READ) begin
          bus_if.I_BUSYWAIT = (ib_left > 0);
          if (ib_left > 0) ib_left--;
        end else bus_if.I_BUSYWAIT = 1'($urandom);
        if (bus_if.D_READ || bus_if.D_WRITE) begin
          bus_if.D_BUSYWAIT = (db_left > 0);
          if (db_left > 0) db_left--;
        end else bus_if.D_BUSYWAIT = 1'($urandom);
        @(negedge clk);
      end
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " pc"}, bus_if.PC, v.exp_pc);
    chk({nm, " latency"}, 32'(n), 32'(v.exp_lat));
    chk({nm, " ir_load count"}, 32'(nir), 32'd1);
    chk({nm, " reg_write count"}, 32'(nrw), 32'(v.exp_rw));
    chk({nm, " d_read cycles"}, 32'(nrd), v.rd ? 32'(1 + v.db) : 32'd0);
    chk({nm, " d_write cycles"}, 32'(nwr), (v.wr && !v.rd) ? 32'(1 + v.db) : 32'd0);
    chk({nm, " wb_sel cycles"}, 32'(nwb), v.rd ? 32'd1 : 32'd0);
    chk({nm, " strobe overlap"}, 32'(bad), 32'd0);
    chk({nm, " pc stable"}, 32'(pcmv), 32'd0);
    chk({nm, " fault"}, 32'(nflt), 32'd0);
  endtask

  initial begin
    vec_t v;
    int k;
    logic [31:0] frozen;

    // jmp br rd wr rw z off ib db exp_pc exp_lat exp_rw
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,0,0,32'h0000_0004,2,1};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,8'h00,0,0,32'h0000_0008,2,1};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,1,0,32'h0000_000C,3,1};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,0,0,32'h0000_0010,2,1};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hFE,0,0,32'h0000_000C,2,0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,0,0,32'h0000_0010,2,1};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'hFE,0,0,32'h0000_0014,2,0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h00,0,3,32'h0000_0018,7,1};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,2,0,32'h0000_001C,5,0};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h80,0,0,32'hFFFF_FE20,2,0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,0,0,32'hFFFF_FE24,4,1};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h7F,0,0,32'h0000_0024,2,0};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h00,0,1,32'h0000_0028,4,0};

    rst_n = 1'b0;
    bus_if.I_BUSYWAIT = 1'b0; bus_if.D_BUSYWAIT = 1'b0;
    bus_if.IS_JUMP = 1'b0; bus_if.IS_BRANCH = 1'b0; bus_if.MEM_RD_REQ = 1'b0;
    bus_if.MEM_WR_REQ = 1'b0; bus_if.REG_WR_REQ = 1'b0; bus_if.ZERO = 1'b0;
    bus_if.OFFSET = 8'h00;
    #1;
    chk("reset pc", bus_if.PC, 32'h0);
    chk("reset strobes", {25'd0, bus_if.I_READ, bus_if.IR_LOAD, bus_if.D_READ, bus_if.D_WRITE,
                          bus_if.REG_WRITE, bus_if.WB_SEL_MEM, bus_if.FAULT}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_instr($sformatf("tbl%0d", i), tbl[i]);

    // Reset asserted mid-MEM of a stalled load: strobes drop at once, no write.
    bus_if.IS_JUMP = 1'b0; bus_if.IS_BRANCH = 1'b0; bus_if.MEM_RD_REQ = 1'b1;
    bus_if.MEM_WR_REQ = 1'b0; bus_if.REG_WR_REQ = 1'b1;
    bus_if.I_BUSYWAIT = 1'b0; bus_if.D_BUSYWAIT = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("abort d_read before reset", 32'(bus_if.D_READ), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort d_read", 32'(bus_if.D_READ), 32'd0);
    chk("abort pc", bus_if.PC, 32'h0);
    chk("abort i_read", 32'(bus_if.I_READ), 32'd0);
    chk("abort reg_write", 32'(bus_if.REG_WRITE), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.D_BUSYWAIT = 1'b0;
    #1;
    chk("post-reset i_read", 32'(bus_if.I_READ), 32'd1);
    chk("post-reset pc", bus_if.PC, 32'h0);
    run_instr("post-reset add", tbl[0]);
    pc_model = 32'h4;

    // Randomized instructions against the model.
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 4));
      v.jmp = (k == 2) || ($urandom_range(0, 7) == 0);
      v.br  = (k == 1);
      v.rd  = (k == 3) || ((k == 4) && ($urandom_range(0, 3) == 0));
      v.wr  = (k == 4);
      v.rw  = (k == 0) || (k == 3) || 1'($urandom);
      v.z   = 1'($urandom);
      v.off = 8'($urandom);
      v.ib  = int'($urandom_range(0, 3));
      v.db  = int'($urandom_range(0, 3));
      if (v.rd || v.wr) v.jmp = 1'b0;
      v.exp_pc  = model_pc(pc_model, v.jmp, v.br, v.z, v.off);
      v.exp_lat = model_lat(v);
      v.exp_rw  = (v.rd || v.wr) ? int'(v.rd) : int'(v.rw);
      run_instr($sformatf("rnd%0d", i), v);
      pc_model = v.exp_pc;
    end

`ifdef SEQ_TIMEOUT_EN
    // Stuck data memory: FAULT after exactly 4 stalled MEM cycles, then HALT.
    bus_if.IS_JUMP = 1'b0; bus_if.IS_BRANCH = 1'b0; bus_if.MEM_RD_REQ = 1'b1;
    bus_if.MEM_WR_REQ = 1'b0; bus_if.REG_WR_REQ = 1'b1;
    bus_if.I_BUSYWAIT = 1'b0; bus_if.D_BUSYWAIT = 1'b1;
    k = 0;
    while (!bus_if.D_READ && k < 20) begin @(negedge clk); k++; end
    k = 0;
    while (bus_if.D_READ && !bus_if.FAULT && k < 50) begin k++; @(negedge clk); end
    chk("timeout fault", 32'(bus_if.FAULT), 32'd1);
    chk("timeout stall cycles", 32'(k), 32'd4);
    frozen = bus_if.PC;
    chk("timeout pc", frozen, pc_model);
    for (int i = 0; i < 10; i++) begin
      bus_if.I_BUSYWAIT = 1'($urandom);
      bus_if.D_BUSYWAIT = 1'($urandom);
      @(negedge clk);
      chk("halt strobes", {27'd0, bus_if.I_READ, bus_if.IR_LOAD, bus_if.D_READ, bus_if.D_WRITE,
                           bus_if.REG_WRITE}, 32'h0);
      chk("halt pc", bus_if.PC, frozen);
      chk("halt fault", 32'(bus_if.FAULT), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("fault cleared", 32'(bus_if.FAULT), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_instr("after halt add", tbl[0]);
`else
    // Without the watchdog a long data stall just waits, FAULT stays 0.
    v = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h00,0,300,32'h0,0,1};
    v.exp_pc  = model_pc(pc_model, 1'b0, 1'b0, 1'b0, 8'h00);
    v.exp_lat = model_lat(v);
    run_instr("long stall load", v);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
